// File: rtl/ddc_ctrl_pkg.sv
// Shared types for the DDC retune controller and the DDS wrapper.
package ddc_ctrl_pkg;

  localparam int PHASE_W_DEF = 32;

  typedef logic [PHASE_W_DEF-1:0] pinc_t;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_DWELL,
    ST_FLUSH,
    ST_RUN
  } state_e;

endpackage

// File: rtl/ddc_pinc_step.sv
// One ramp step: move cur toward tgt by at most MAX_STEP (increments are magnitudes, no wrap).
module ddc_pinc_step #(
  parameter int                 PHASE_W  = 32,
  parameter logic [PHASE_W-1:0] MAX_STEP = 32'h0100_0000
) (
  input  logic [PHASE_W-1:0] cur_i,
  input  logic [PHASE_W-1:0] tgt_i,
  output logic [PHASE_W-1:0] next_o
);

  logic signed [PHASE_W:0] diff;
  logic signed [PHASE_W:0] max_s;

  always_comb begin
    // One extra bit so the full unsigned range difference never overflows.
    diff  = $signed({1'b0, tgt_i}) - $signed({1'b0, cur_i});
    max_s = $signed({1'b0, MAX_STEP});
    if (diff > max_s)
      next_o = cur_i + MAX_STEP;
    else if (diff < -max_s)
      next_o = cur_i - MAX_STEP;
    else
      next_o = tgt_i;
  end

endmodule

// File: rtl/ddc_tune_ctrl.sv
// Retune controller: ramps the DDS phase increment to a requested target and blanks I/Q until the mixer flushes.
module ddc_tune_ctrl
  import ddc_ctrl_pkg::*;
#(
  parameter int                 PHASE_W   = 32,
  parameter logic [PHASE_W-1:0] INIT_PINC = 32'h4000_0000,
  parameter logic [PHASE_W-1:0] MAX_STEP  = 32'h0100_0000,
  parameter int                 DWELL_CYC = 4,
  parameter int                 FLUSH_CYC = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] req_tdata,
  input  logic               req_tvalid,
  output logic               req_tready,
  output logic [PHASE_W-1:0] cfg_tdata,
  output logic               cfg_tvalid,
  input  logic               cfg_tready,
  output logic [PHASE_W-1:0] cur_pinc,
  output logic               iq_valid,
  output logic               busy
);

  localparam int CNT_MAX = (DWELL_CYC > FLUSH_CYC) ? DWELL_CYC : FLUSH_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'((DWELL_CYC > 0) ? DWELL_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] cfg_tdata_q, cfg_tdata_d;
  logic [PHASE_W-1:0] cur_q, cur_d;
  logic [PHASE_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cfg_tvalid_q, cfg_tvalid_d;
  logic               iq_valid_q, iq_valid_d;
  logic               req_tready_q, req_tready_d;
  logic               busy_q, busy_d;

  logic [PHASE_W-1:0] step_tgt;
  logic [PHASE_W-1:0] step_next;

  // Outside LOAD cfg_tdata_q always equals cur_q; in LOAD it is the word about to become cur,
  // so it is the right base for the next step in every state.
  assign step_tgt = (state_q == ST_RUN) ? req_tdata : tgt_q;

  ddc_pinc_step #(
    .PHASE_W  (PHASE_W),
    .MAX_STEP (MAX_STEP)
  ) u_step (
    .cur_i  (cfg_tdata_q),
    .tgt_i  (step_tgt),
    .next_o (step_next)
  );

  always_comb begin
    state_d     = state_q;
    cfg_tdata_d = cfg_tdata_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    cnt_d       = cnt_q;
    case (state_q)
      ST_LOAD: begin
        if (cfg_tvalid_q && cfg_tready) begin
          cur_d = cfg_tdata_q;
          cnt_d = '0;
          if (cfg_tdata_q == tgt_q) begin
            state_d = (FLUSH_CYC == 0) ? ST_RUN : ST_FLUSH;
          end else if (DWELL_CYC == 0) begin
            cfg_tdata_d = step_next;
          end else begin
            state_d = ST_DWELL;
          end
        end
      end
      ST_DWELL: begin
        if (cnt_q == DWELL_LAST) begin
          state_d     = ST_LOAD;
          cfg_tdata_d = step_next;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == FLUSH_LAST)
          state_d = ST_RUN;
        else
          cnt_d = cnt_q + CNT_W'(1);
      end
      ST_RUN: begin
        if (req_tvalid && req_tready_q) begin
          tgt_d = req_tdata;
          // Retuning to the current increment needs no write and no blanking.
          if (req_tdata != cur_q) begin
            state_d     = ST_LOAD;
            cfg_tdata_d = step_next;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase

    cfg_tvalid_d = (state_d == ST_LOAD);
    iq_valid_d   = (state_d == ST_RUN);
    req_tready_d = (state_d == ST_RUN);
    busy_d       = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      cfg_tdata_q  <= INIT_PINC;
      cur_q        <= INIT_PINC;
      tgt_q        <= INIT_PINC;
      cnt_q        <= '0;
      cfg_tvalid_q <= 1'b0;
      iq_valid_q   <= 1'b0;
      req_tready_q <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cfg_tdata_q  <= cfg_tdata_d;
      cur_q        <= cur_d;
      tgt_q        <= tgt_d;
      cnt_q        <= cnt_d;
      cfg_tvalid_q <= cfg_tvalid_d;
      iq_valid_q   <= iq_valid_d;
      req_tready_q <= req_tready_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_tdata  = cfg_tdata_q;
  assign cfg_tvalid = cfg_tvalid_q;
  assign cur_pinc   = cur_q;
  assign iq_valid   = iq_valid_q;
  assign req_tready = req_tready_q;
  assign busy       = busy_q;

endmodule
